// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit: MIPS-style load/store unit sitting between a request
// port and a word-wide memory (combinational read, write at rising edge).
// Byte and halfword stores are done as read-modify-write of the containing word.
//
// Parameters:
//   BIG_ENDIAN      0: byte lane = addr[1:0]; 1: byte lane = 3 - addr[1:0]
// Optional feature:
//   MIPS_LSU_ALIGN_CHECK_EN  when defined, misaligned half/word requests
//                            complete immediately with resp_error=1 and no
//                            memory access.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 store, 0 load
//   req_size            00 byte, 01 half, 10/11 word
//   req_unsigned        zero-extend sub-word loads
//   req_address         byte address
//   req_wdata           store data (low bits for sub-word stores)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 when not valid and for stores)
//   resp_error          misaligned access (only with the alignment check)
//   mem_address         word-aligned memory address
//   mem_write_data      memory write data
//   sig_mem_read/write  memory strobes, never both high
//   mem_read_data       memory read data
module mips_load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t              state, state_nxt;
    logic                lat_write, lat_write_nxt;
    logic [1:0]          lat_size, lat_size_nxt;
    logic                lat_unsigned, lat_unsigned_nxt;
    logic [DATA_W-1:0]   lat_addr, lat_addr_nxt;
    logic [DATA_W-1:0]   lat_wdata, lat_wdata_nxt;

    logic                req_ready_nxt;
    logic                resp_valid_nxt;
    logic [DATA_W-1:0]   resp_rdata_nxt;
    logic                resp_error_nxt;
    logic [DATA_W-1:0]   mem_address_nxt;
    logic [DATA_W-1:0]   mem_write_data_nxt;
    logic                sig_mem_read_nxt;
    logic                sig_mem_write_nxt;

    logic                misaligned_c;
    logic [DATA_W-1:0]   word_addr_c;

    // Byte lane selected by the low address bits.
    function automatic logic [1:0] byte_lane(input logic [1:0] addr_lo);
        return BIG_ENDIAN ? 2'(2'd3 - addr_lo) : addr_lo;
    endfunction

    // 1 when the halfword lives in bits [31:16].
    function automatic logic half_upper(input logic addr_bit1);
        return addr_bit1 ^ BIG_ENDIAN;
    endfunction

    // Extract and extend the addressed byte/half from a memory word.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic              uns,
        input logic [1:0]        addr_lo
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{byte_lane(addr_lo), 3'b000} +: 8];
        h = half_upper(addr_lo[1]) ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of the old word with store data.
    function automatic logic [DATA_W-1:0] store_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [1:0]        size,
        input logic [1:0]        addr_lo
    );
        logic [DATA_W-1:0] r;
        r = old;
        case (size)
            2'b00:   r[{byte_lane(addr_lo), 3'b000} +: 8] = wdata[7:0];
            2'b01:   r[{half_upper(addr_lo[1]), 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

`ifdef MIPS_LSU_ALIGN_CHECK_EN
    // Half needs addr[0]=0, word needs addr[1:0]=0.
    assign misaligned_c = ((req_size == 2'b01) && req_address[0]) ||
                          (req_size[1] && (req_address[1:0] != 2'b00));
`else
    assign misaligned_c = 1'b0;
`endif

    assign word_addr_c = {lat_addr[31:2], 2'b00};

    // Next state and next registered outputs.
    always_comb begin
        state_nxt          = state;
        lat_write_nxt      = lat_write;
        lat_size_nxt       = lat_size;
        lat_unsigned_nxt   = lat_unsigned;
        lat_addr_nxt       = lat_addr;
        lat_wdata_nxt      = lat_wdata;
        req_ready_nxt      = 1'b0;
        resp_valid_nxt     = 1'b0;
        resp_rdata_nxt     = '0;
        resp_error_nxt     = 1'b0;
        mem_address_nxt    = '0;
        mem_write_data_nxt = '0;
        sig_mem_read_nxt   = 1'b0;
        sig_mem_write_nxt  = 1'b0;

        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    lat_write_nxt    = req_write;
                    lat_size_nxt     = req_size;
                    lat_unsigned_nxt = req_unsigned;
                    lat_addr_nxt     = req_address;
                    lat_wdata_nxt    = req_wdata;
                    req_ready_nxt    = 1'b0;
                    if (misaligned_c) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_error_nxt = 1'b1;
                    end else if (!req_write) begin
                        state_nxt        = ACCESS;
                        sig_mem_read_nxt = 1'b1;
                        mem_address_nxt  = {req_address[31:2], 2'b00};
                    end else if (!req_size[1]) begin
                        // Sub-word store: fetch the word first.
                        state_nxt        = READ;
                        sig_mem_read_nxt = 1'b1;
                        mem_address_nxt  = {req_address[31:2], 2'b00};
                    end else begin
                        state_nxt          = ACCESS;
                        sig_mem_write_nxt  = 1'b1;
                        mem_address_nxt    = {req_address[31:2], 2'b00};
                        mem_write_data_nxt = req_wdata;
                    end
                end
            end
            ACCESS: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
                if (!lat_write) begin
                    resp_rdata_nxt = load_extend(mem_read_data, lat_size,
                                                 lat_unsigned, lat_addr[1:0]);
                end
            end
            READ: begin
                state_nxt          = WRITE;
                sig_mem_write_nxt  = 1'b1;
                mem_address_nxt    = word_addr_c;
                mem_write_data_nxt = store_merge(mem_read_data, lat_wdata,
                                                 lat_size, lat_addr[1:0]);
            end
            WRITE: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
            end
            RESP: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
            end
            default: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_write      <= 1'b0;
            lat_size       <= 2'b00;
            lat_unsigned   <= 1'b0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            sig_mem_read   <= 1'b0;
            sig_mem_write  <= 1'b0;
        end else begin
            state          <= state_nxt;
            lat_write      <= lat_write_nxt;
            lat_size       <= lat_size_nxt;
            lat_unsigned   <= lat_unsigned_nxt;
            lat_addr       <= lat_addr_nxt;
            lat_wdata      <= lat_wdata_nxt;
            req_ready      <= req_ready_nxt;
            resp_valid     <= resp_valid_nxt;
            resp_rdata     <= resp_rdata_nxt;
            resp_error     <= resp_error_nxt;
            mem_address    <= mem_address_nxt;
            mem_write_data <= mem_write_data_nxt;
            sig_mem_read   <= sig_mem_read_nxt;
            sig_mem_write  <= sig_mem_write_nxt;
        end
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed testbench for mips_load_store_unit: one little-endian and one
// big-endian instance, each with its own word memory model.
module tb_mips_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_wdata = '0;
    logic        le_valid = 1'b0, be_valid = 1'b0;

    logic        le_ready, le_rvalid, le_err, le_rd, le_wr;
    logic [31:0] le_rdata, le_maddr, le_mwdata, le_mrdata;
    logic        be_ready, be_rvalid, be_err, be_rd, be_wr;
    logic [31:0] be_rdata, be_maddr, be_mwdata, be_mrdata;

    logic [31:0] le_mem [64];
    logic [31:0] be_mem [64];
    logic        pre_en = 1'b0, pre_be = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    int rd0, wr0;

    always #5 clock = ~clock;

    mips_load_store_unit #(.BIG_ENDIAN(1'b0)) u_le (
        .clock(clock), .reset(reset),
        .req_valid(le_valid), .req_ready(le_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(le_rvalid), .resp_rdata(le_rdata), .resp_error(le_err),
        .mem_address(le_maddr), .mem_write_data(le_mwdata),
        .sig_mem_read(le_rd), .sig_mem_write(le_wr), .mem_read_data(le_mrdata)
    );

    mips_load_store_unit #(.BIG_ENDIAN(1'b1)) u_be (
        .clock(clock), .reset(reset),
        .req_valid(be_valid), .req_ready(be_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(be_rvalid), .resp_rdata(be_rdata), .resp_error(be_err),
        .mem_address(be_maddr), .mem_write_data(be_mwdata),
        .sig_mem_read(be_rd), .sig_mem_write(be_wr), .mem_read_data(be_mrdata)
    );

    assign le_mrdata = le_mem[6'(le_maddr >> 2)];
    assign be_mrdata = be_mem[6'(be_maddr >> 2)];

    // Memory models with a preload port; strobe counters for the LE instance.
    always @(posedge clock) begin
        if (pre_en && !pre_be) le_mem[pre_idx] <= pre_data;
        else if (le_wr) le_mem[6'(le_maddr >> 2)] <= le_mwdata;
        if (pre_en && pre_be) be_mem[pre_idx] <= pre_data;
        else if (be_wr) be_mem[6'(be_maddr >> 2)] <= be_mwdata;
        if (le_rd) rd_cnt <= rd_cnt + 1;
        if (le_wr) wr_cnt <= wr_cnt + 1;
        if ((le_rd && le_wr) || (be_rd && be_wr)) both_cnt <= both_cnt + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic be, input logic [5:0] idx, input logic [31:0] data);
        pre_en = 1'b1; pre_be = be; pre_idx = idx; pre_data = data;
        tick();
        pre_en = 1'b0;
    endtask

    // Present one request for one edge; returns in the first cycle after acceptance.
    task automatic start(input logic be, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        req_write = wr; req_size = size; req_unsigned = uns;
        req_address = addr; req_wdata = wdata;
        le_valid = !be; be_valid = be;
        tick();
        le_valid = 1'b0; be_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_ready", 32'(le_ready), 32'd1);
        check("rst_rvalid", 32'(le_rvalid), 32'd0);
        check("rst_strobes", {30'd0, le_rd, le_wr}, 32'd0);
        check("rst_maddr", le_maddr, 32'd0);
        check("rst_rdata", le_rdata, 32'd0);
        reset = 1'b0;
        tick();
        preload(1'b0, 6'd4, 32'h8899AABB);
        preload(1'b0, 6'd9, 32'h0BADF00D);
        preload(1'b1, 6'd0, 32'h11223344);

        // Signed byte load 0x11
        start(1'b0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check("lb_rd_strobe", 32'(le_rd), 32'd1);
        check("lb_maddr", le_maddr, 32'h10);
        check("lb_ready_low", 32'(le_ready), 32'd0);
        check("lb_rvalid_early", 32'(le_rvalid), 32'd0);
        tick();
        check("lb_rvalid", 32'(le_rvalid), 32'd1);
        check("lb_rdata", le_rdata, 32'hFFFFFFAA);
        check("lb_err", 32'(le_err), 32'd0);
        check("resp_maddr", le_maddr, 32'd0);
        tick();
        check("lb_idle_rvalid", 32'(le_rvalid), 32'd0);
        check("lb_idle_rdata", le_rdata, 32'd0);
        check("lb_idle_ready", 32'(le_ready), 32'd1);

        // Unsigned byte load 0x11
        start(1'b0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        tick();
        check("lbu_rdata", le_rdata, 32'h000000AA);
        tick();

        // Signed half load 0x10
        start(1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        tick();
        check("lh_rdata", le_rdata, 32'hFFFFAABB);
        tick();

        // Half store 0x1234 to 0x12: read, then merged write
        rd0 = rd_cnt; wr0 = wr_cnt;
        start(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
        check("sh_read_phase", {30'd0, le_rd, le_wr}, 32'd2);
        check("sh_read_maddr", le_maddr, 32'h10);
        tick();
        check("sh_write_phase", {30'd0, le_rd, le_wr}, 32'd1);
        check("sh_wdata", le_mwdata, 32'h1234AABB);
        check("sh_write_maddr", le_maddr, 32'h10);
        tick();
        check("sh_rvalid", 32'(le_rvalid), 32'd1);
        check("sh_rdata_zero", le_rdata, 32'd0);
        check("sh_mem", le_mem[4], 32'h1234AABB);
        check("sh_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        check("sh_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        tick();

        // Byte store 0x55 to 0x13, then signed byte load back
        start(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hABCDEF55);
        tick(); tick(); tick();
        check("sb_mem", le_mem[4], 32'h5534AABB);
        start(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        tick();
        check("lb_pos_rdata", le_rdata, 32'h00000055);
        tick();

        // Word store 0xDEADBEEF to 0x20
        start(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        check("sw_wr_strobe", {30'd0, le_rd, le_wr}, 32'd1);
        check("sw_wdata", le_mwdata, 32'hDEADBEEF);
        check("sw_ready_low", 32'(le_ready), 32'd0);
        tick();
        check("sw_rvalid", 32'(le_rvalid), 32'd1);
        check("sw_ready_low_resp", 32'(le_ready), 32'd0);
        tick();
        check("sw_mem", le_mem[8], 32'hDEADBEEF);

        // Back-to-back word load 0x20; a store offered mid-flight is ignored
        wr0 = wr_cnt;
        start(1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        req_write = 1'b1; req_size = 2'b10; req_address = 32'h24; req_wdata = 32'h0;
        le_valid = 1'b1;
        tick();
        le_valid = 1'b0;
        check("lw_rvalid", 32'(le_rvalid), 32'd1);
        check("lw_rdata", le_rdata, 32'hDEADBEEF);
        tick();
        check("ignored_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("ignored_mem", le_mem[9], 32'h0BADF00D);

        // Misaligned word load 0x22
        rd0 = rd_cnt;
        start(1'b0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
        check("mis_rvalid", 32'(le_rvalid), 32'd1);
        check("mis_err", 32'(le_err), 32'd1);
        check("mis_rdata", le_rdata, 32'd0);
        tick();
        check("mis_no_read", 32'(rd_cnt - rd0), 32'd0);
`else
        check("mis_maddr", le_maddr, 32'h20);
        tick();
        check("mis_rdata", le_rdata, 32'hDEADBEEF);
        check("mis_err", 32'(le_err), 32'd0);
        tick();
        check("mis_read", 32'(rd_cnt - rd0), 32'd1);
`endif

        // Reset while writing a byte store
        start(1'b0, 1'b1, 2'b00, 1'b0, 32'h25, 32'h77);
        tick();
        check("abort_in_write", 32'(le_wr), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_wr_low", 32'(le_wr), 32'd0);
        check("abort_ready", 32'(le_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        check("abort_mem", le_mem[9], 32'h0BADF00D);
        check("abort_no_resp", 32'(le_rvalid), 32'd0);

        // Big-endian instance
        start(1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        tick();
        check("be_lhu_rdata", be_rdata, 32'h00003344);
        tick();
        start(1'b1, 1'b0, 2'b00, 1'b0, 32'h1, 32'h0);
        tick();
        check("be_lb_rdata", be_rdata, 32'h00000022);
        tick();
        start(1'b1, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0000BEEF);
        tick(); tick(); tick();
        check("be_sh_mem", be_mem[0], 32'hBEEF3344);

        check("never_both_strobes", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_load_store_unit.md
MIPS_LOAD_STORE_UNIT -- requirements
Module: mips_load_store_unit

Interface
REQ-001 SHALL have parameter: BIG_ENDIAN, default 0, byte-lane order (0: lane = addr[1:0]; 1: lane = 3 - addr[1:0]).
REQ-002 SHALL have port: clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req_valid in 1 request present; req_ready out 1 unit can accept; req_write in 1 store(1)/load(0); req_size in 2 00 byte/01 half/10 word/11 treated as word; req_unsigned in 1 zero-extend loads; req_address in 32 byte address; req_wdata in 32 store data (low bits used for sub-word).
REQ-005 SHALL have ports: resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 extended load data; resp_error out 1 misaligned access.
REQ-006 SHALL have memory-side ports: mem_address out 32; mem_write_data out 32; sig_mem_read out 1; sig_mem_write out 1; mem_read_data in 32 (word memory, combinational read, write at rising edge).

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, READ, WRITE, RESP; one request in flight.
REQ-008 SHALL assert req_ready only in IDLE; accept on rising edge with req_valid && req_ready, latching all req_* fields.
REQ-009 SHALL drive mem_address = {latched addr[31:2], 2'b00} in ACCESS/READ/WRITE, 0 otherwise; never issue unaligned memory addresses.
REQ-010 Load: IDLE -> ACCESS (sig_mem_read=1, capture mem_read_data) -> RESP; resp_valid high 2 cycles after acceptance edge.
REQ-011 Word store: IDLE -> ACCESS (sig_mem_write=1, mem_write_data = wdata) -> RESP.
REQ-012 Byte/half store: IDLE -> READ (sig_mem_read=1, capture word) -> WRITE (sig_mem_write=1, mem_write_data = captured word with selected lane(s) replaced) -> RESP; other bytes SHALL be preserved.
REQ-013 Lane select: byte lane per BIG_ENDIAN; halfword occupies lanes {addr[1],0}/{addr[1],1}, bits [15:0] at addr[1]=0 for little-endian, bits [31:16] at addr[1]=0 for big-endian.
REQ-014 Load extension: byte/half sign-extended when req_unsigned=0, zero-extended when 1; word loads unmodified.
REQ-015 RESP lasts exactly one cycle, resp_valid=1, then IDLE; resp_rdata valid only while resp_valid, 0 otherwise and 0 for stores.
REQ-016 sig_mem_read and sig_mem_write SHALL never be high in the same cycle; both 0 in IDLE and RESP.
REQ-017 req_valid in non-IDLE states SHALL be ignored (no queuing); back-to-back requests accepted earliest in the cycle after RESP.

Reset
REQ-018 reset SHALL asynchronously force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_address=0, mem_write_data=0, sig_mem_read=0, sig_mem_write=0.
REQ-019 Reset during WRITE SHALL deassert sig_mem_write immediately; aborted request produces no response.

Configuration
REQ-020 With MIPS_LSU_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE -> RESP directly, no memory strobe, resp_error=1, resp_rdata=0.
REQ-021 Without MIPS_LSU_ALIGN_CHECK_EN: resp_error tied 0; half ignores addr[0], word ignores addr[1:0].

Verification
REQ-022 Memory word 0x10 = 0x8899AABB, BIG_ENDIAN=0, load byte signed addr 0x11 -> resp_rdata 0xFFFFFFAA 2 cycles after accept; unsigned -> 0x000000AA.
REQ-023 Same word, store half 0x1234 to addr 0x12 -> one read strobe, then one write strobe of 0x1234AABB at mem_address 0x10, resp_valid after 3 cycles.
REQ-024 Word store 0xDEADBEEF to 0x20 then word load 0x20 -> 0xDEADBEEF; req_ready low between accept and RESP.
REQ-025 Macro defined, word load addr 0x22 -> resp_error=1, resp_rdata=0, no sig_mem_read pulse; macro undefined -> reads word 0x20, resp_error=0.
REQ-026 Assert reset during WRITE of a byte store -> sig_mem_write falls same cycle, target word unchanged, no resp_valid, req_ready=1.
REQ-027 BIG_ENDIAN=1, word 0x11223344 at 0x0, load half unsigned addr 0x2 -> 0x00003344.
